// File: rtl/bc_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
//   loader_state_t  : loader FSM state encoding
//   BYTE_WIDTH      : width of one byte-stream beat
//   bytes_per_word  : number of byte beats per memory word
package bc_loader_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} loader_state_t;

  localparam int BYTE_WIDTH = 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/cg_memory_interface.sv
// Memory port bundle shared by the imem writer (loader) and the memory.
//   wen         : write strobe
//   wdata_valid : write data qualifier (asserted together with wen)
//   waddr       : word address
//   wdata       : write data
interface CG_memory_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  wen;
  logic                  wdata_valid;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  modport writer (output wen, wdata_valid, waddr, wdata);
  modport mem    (input  wen, wdata_valid, waddr, wdata);
endinterface

// File: rtl/bc_byte_packer.sv
// Little-endian byte-to-word assembler.
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_clr         : drop any partial word and restart at byte 0 (wins over push)
//   i_push        : a byte is being accepted this cycle
//   i_byte        : byte data
//   o_word        : word including the byte presented this cycle
//   o_full        : this push completes the word (o_word is then final)
module bc_byte_packer
  import bc_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_full
);
  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] w_next;
  logic                  w_last;

  assign w_last = (r_idx == IDX_W'(BPW - 1));

  // Current byte merged into its lane so the top can capture a full word
  // in the same cycle the last byte arrives.
  always_comb begin
    w_next = r_word;
    w_next[r_idx*BYTE_WIDTH +: BYTE_WIDTH] = i_byte;
  end

  assign o_word = w_next;
  assign o_full = i_push & w_last;

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_push) begin
      if (w_last) begin
        r_idx  <= '0;
        r_word <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
        r_word <= w_next;
      end
    end
  end

endmodule

// File: rtl/bc_imem_loader.sv
// Instruction-memory loader: takes a host byte stream, packs little-endian
// words and writes them to consecutive word addresses while holding the
// fetch stage in pipeline reset.
//   i_clk, i_rstn   : clock, synchronous active-low reset
//   if_mem          : memory write port (wen, wdata_valid, waddr, wdata)
//   i_start         : begin a load (IDLE only); latches base and count
//   i_abort         : cancel the load in COLLECT/WRITE
//   i_base_addr     : first word address
//   i_word_count    : words to load (0 = immediate done)
//   i_byte_valid/i_byte/o_byte_ready : byte-stream handshake
//   o_busy          : load in progress
//   o_done          : one-cycle completion pulse
//   o_core_prst     : pipeline reset to the fetch stage
//   o_checksum      : XOR of words written in the current/last load
module bc_imem_loader
  import bc_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  CG_memory_interface.writer    if_mem,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_word_count,
  input  logic                  i_byte_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic                  o_byte_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_core_prst,
  output logic [DATA_WIDTH-1:0] o_checksum
);
  loader_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_wcnt;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_byte_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_prst;
  logic [DATA_WIDTH-1:0] r_cksum;

  logic                  w_accept;
  logic                  w_active;
  logic                  w_pk_clr;
  logic                  w_pk_push;
  logic                  w_pk_full;
  logic [DATA_WIDTH-1:0] w_pk_word;
  logic [CNT_WIDTH-1:0]  w_wcnt_inc;

  // ready is only ever high in COLLECT, so accept implies COLLECT
  assign w_accept   = i_byte_valid & r_byte_ready;
  assign w_active   = (r_state == COLLECT) || (r_state == WRITE);
  // Packer is held clear in IDLE and on abort; abort beats a final byte.
  assign w_pk_clr   = (r_state == IDLE) || (w_active && i_abort);
  assign w_pk_push  = w_accept & ~i_abort;
  assign w_wcnt_inc = r_wcnt + 1'b1;

  bc_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_pk_clr),
    .i_push (w_pk_push),
    .i_byte (i_byte),
    .o_word (w_pk_word),
    .o_full (w_pk_full)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_count      <= '0;
      r_wcnt       <= '0;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_prst       <= 1'b0;
      r_cksum      <= '0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_base  <= i_base_addr;
            r_count <= i_word_count;
            r_wcnt  <= '0;
            r_cksum <= '0;
            r_busy  <= 1'b1;
            r_prst  <= 1'b1;
            if (i_word_count == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= COLLECT;
              r_byte_ready <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (i_abort) begin
            r_state      <= IDLE;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_prst       <= 1'b0;
          end else if (w_pk_full) begin
            r_state      <= WRITE;
            r_wen        <= 1'b1;
            r_waddr      <= r_base + ADDR_WIDTH'(r_wcnt);
            r_wdata      <= w_pk_word;
            r_byte_ready <= 1'b0;
          end
        end
        WRITE: begin
          // The strobe is already on the bus this cycle, so the word counts
          // toward the checksum even if an abort arrives alongside it.
          r_cksum <= r_cksum ^ r_wdata;
          r_wcnt  <= w_wcnt_inc;
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_prst  <= 1'b0;
          end else if (w_wcnt_inc == r_count) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= COLLECT;
            r_byte_ready <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_prst  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_mem.wen         = r_wen;
  assign if_mem.wdata_valid = r_wen;
  assign if_mem.waddr       = r_waddr;
  assign if_mem.wdata       = r_wdata;

  assign o_byte_ready = r_byte_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_core_prst  = r_prst;
  assign o_checksum   = r_cksum;

endmodule
